nco_sweep_gen: RTL and testbench
================================

Name: nco_sweep_gen

Overview:
- Parametrised numerically controlled oscillator. It is the successor to the fixed-phase DDS core wrapper.
- Contains its own phase accumulator with a programmable tuning word and phase offset.
- Has an optional linear frequency-sweep (chirp) mode.
- Generates signed quadrature cosine/sine from a quarter-wave ROM. Feeds the modulator/mixer datapath of the WLAN transmitter test chain.

Parameters:
- PHASE_W, 16: accumulator, tuning-word, offset and sweep-register width.
- ADDR_W, 10: phase bits used for lookup (2 quadrant bits plus ADDR_W-2 ROM index bits); ADDR_W >= 4.
- OUT_W, 10: signed output width; peak amplitude A = 2^(OUT_W-1)-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  advance accumulator/sweep this cycle; marks the sample as valid.
- fw_load  in  1  strobe: freq_start<=freq_word, freq_cur<=freq_word.
- freq_word  in  PHASE_W  tuning word / sweep start value (unsigned).
- phase_off  in  PHASE_W  phase offset added after the accumulator; sampled every cycle.
- phase_clr  in  1  strobe: acc<=0.
- mode  in  1  0 = fixed frequency, 1 = linear sweep.
- sweep_step  in  PHASE_W  per-enabled-cycle frequency increment (unsigned).
- sweep_stop  in  PHASE_W  sweep upper bound (unsigned, inclusive).
- cos_out  out  OUT_W  signed cosine.
- sin_out  out  OUT_W  signed sine.
- out_valid  out  1  cos_out/sin_out correspond to an enabled sample.
- sweep_wrap  out  1  one-cycle pulse aligned with the output of the first sample after the sweep reloads.

Behaviour:
- Clock is clk and reset is rst: one clock domain, synchronous active-high reset.
- rst clears acc, freq_start, freq_cur, all pipeline registers, cos_out, sin_out, out_valid and sweep_wrap to 0 on the next edge.
  - rst overrides every other input.
  - Mid-operation reset discards in-flight samples; no valid output appears for 3 cycles after rst deasserts with en=1.
- Stage 0 (control), per edge:
  - If fw_load=1: freq_cur<=freq_word, freq_start<=freq_word.
  - Else if en=1 and mode=1: if freq_cur+sweep_step > sweep_stop, computed at PHASE_W+1 bits to catch overflow, then freq_cur<=freq_start and the wrap flag is set; otherwise freq_cur<=freq_cur+sweep_step.
  - mode=0: freq_cur holds its value.
  - If phase_clr=1: acc<=0. Else if en=1: acc<=acc+freq_cur, mod 2^PHASE_W.
  - phase_clr and fw_load in the same cycle: both apply.
- Stage 1:
  - p <= top ADDR_W bits of (acc + phase_off), mod 2^PHASE_W, using pre-update acc.
  - pc <= p + 2^(ADDR_W-2), i.e. cos(x) = sin(x+90deg), wrapping.
  - valid/wrap flags are delayed alongside.
- Stage 2: quadrant q = top 2 bits, index i = remaining bits. ROM address = i for q=0,2 and ~i for q=1,3. Negate flag = q[1]. Both sin and cos lookups are registered.
- Stage 3: apply negation (two's complement, OUT_W bits) into cos_out/sin_out.
  - out_valid = en delayed 3 cycles.
  - sweep_wrap = wrap flag delayed to align with the first post-reload sample.
- Latency: 3 cycles from en high to out_valid high for that sample. Throughput: 1 sample/cycle.
- With en=0, the outputs keep updating from the held acc; out_valid=0.
- ROM entry k = round(A*sin(pi/2*(k+0.5)/2^(ADDR_W-2))). The half-LSB offset gives exact quadrant symmetry with no entry 2^(ADDR_W-2). Outputs are never -A-1.
- Zero tuning word: constant output, out_valid still follows en.
- sweep_stop < freq_start: wraps every enabled cycle; freq_cur stays at freq_start.

Decomposition:
- Shared package holds:
  - the default widths;
  - the mode encodings MODE_FIXED=0 and MODE_SWEEP=1;
  - the ROM generation function, computed at elaboration with real arithmetic.
- One sub-module: quarter_sine_rom. Parameters ADDR_W-2 and OUT_W. Dual read port, registered, no reset on data.

Test Plan:
- Defaults; rst, then fw_load freq_word=0, phase_off=0, en=1 -> from cycle 3 after en: out_valid=1, sin_out=2, cos_out=511, constant.
- phase_off=0x4000, freq=0 -> sin_out=511, cos_out=-2. phase_off=0x8000 -> sin_out=-2, cos_out=-511.
- freq_word=0x0400, mode=0, en continuous -> acc=0x4000 after 16 enables; output period exactly 64 samples; sin_out max 511 and min -511.
- mode=1, freq_word=0x0100 loaded, step=0x0100, stop=0x0400 -> freq_cur sequence 0x100, 0x200, 0x300, 0x400, 0x100.
  - sweep_wrap pulses once per 4 enabled cycles, 3 cycles after the reload edge.
  - Toggling en=0 mid-sweep freezes the sequence.
- Simultaneous fw_load=1 and wrap condition -> freq_cur takes the new freq_word and no wrap pulse occurs. phase_clr with en=1 -> acc=0 next cycle.
- rst asserted mid-sweep with en=1 -> the next cycle shows all outputs 0 and out_valid=0 for 3 cycles after release; the sequence restarts from acc=0 and freq_cur=0 until fw_load.

Source files
------------

// File: rtl/nco_sweep_gen_pkg.sv
// Shared widths, mode encodings and the quarter-wave ROM generator for the NCO sweep generator.
package nco_sweep_gen_pkg;

  localparam int unsigned DEF_PHASE_W = 16;
  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_OUT_W   = 10;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_SWEEP = 1'b1
  } mode_e;

  localparam real PI_HALF = 1.5707963267948966;

  // Half-LSB phase offset keeps the table symmetric across quadrant folds.
  function automatic int rom_entry(int unsigned k, int unsigned idx_w, int unsigned out_w);
    real amp;
    real ang;
    amp = real'((1 << (out_w - 1)) - 1);
    ang = PI_HALF * (real'(k) + 0.5) / real'(1 << idx_w);
    return $rtoi(amp * $sin(ang) + 0.5);
  endfunction

endpackage

// File: rtl/nco_sweep_gen_if.sv
// Control/sample bundle between a driver and the NCO sweep generator.
interface nco_sweep_gen_if #(
  parameter int unsigned PHASE_W = nco_sweep_gen_pkg::DEF_PHASE_W,
  parameter int unsigned OUT_W   = nco_sweep_gen_pkg::DEF_OUT_W
);
  logic               en;
  logic               fw_load;
  logic [PHASE_W-1:0] freq_word;
  logic [PHASE_W-1:0] phase_off;
  logic               phase_clr;
  logic               mode;
  logic [PHASE_W-1:0] sweep_step;
  logic [PHASE_W-1:0] sweep_stop;
  logic [OUT_W-1:0]   cos_out;
  logic [OUT_W-1:0]   sin_out;
  logic               out_valid;
  logic               sweep_wrap;

  modport master (
    output en, fw_load, freq_word, phase_off, phase_clr, mode, sweep_step, sweep_stop,
    input  cos_out, sin_out, out_valid, sweep_wrap
  );

  modport slave (
    input  en, fw_load, freq_word, phase_off, phase_clr, mode, sweep_step, sweep_stop,
    output cos_out, sin_out, out_valid, sweep_wrap
  );
endinterface

// File: rtl/nco_sweep_gen_rom.sv
// First-quadrant sine magnitude table with two registered read ports; data is not reset.
module quarter_sine_rom
  import nco_sweep_gen_pkg::*;
#(
  parameter int unsigned IDX_W = DEF_ADDR_W - 2,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] addr_a,
  input  logic [IDX_W-1:0] addr_b,
  output logic [OUT_W-1:0] data_a,
  output logic [OUT_W-1:0] data_b
);
  localparam int unsigned Depth = 2 ** IDX_W;

  logic [OUT_W-1:0] rom_tbl [Depth];

  for (genvar k = 0; k < Depth; k++) begin : g_tbl
    assign rom_tbl[k] = OUT_W'(rom_entry(k, IDX_W, OUT_W));
  end

  always_ff @(posedge clk) begin
    data_a <= rom_tbl[addr_a];
    data_b <= rom_tbl[addr_b];
  end

endmodule

// File: rtl/nco_sweep_gen.sv
// Phase-accumulator NCO with optional linear chirp and quadrature quarter-wave ROM output.
module nco_sweep_gen
  import nco_sweep_gen_pkg::*;
#(
  parameter int unsigned PHASE_W = DEF_PHASE_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned OUT_W   = DEF_OUT_W
) (
  input logic            clk,
  input logic            rst,
  nco_sweep_gen_if.slave bus
);
  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] Quarter = {2'b01, {IDX_W{1'b0}}};

  // Stage 0: frequency/sweep control and accumulator
  logic [PHASE_W-1:0] acc_q;
  logic [PHASE_W-1:0] freq_start_q;
  logic [PHASE_W-1:0] freq_cur_q;
  logic               wrap_q;
  logic [PHASE_W:0]   sweep_next;
  logic               sweep_over;

  // Extra bit so a step that overflows PHASE_W still counts as passing the stop value.
  assign sweep_next = {1'b0, freq_cur_q} + {1'b0, bus.sweep_step};
  assign sweep_over = sweep_next > {1'b0, bus.sweep_stop};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      freq_start_q <= '0;
      freq_cur_q   <= '0;
      wrap_q       <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (bus.fw_load) begin
        freq_cur_q   <= bus.freq_word;
        freq_start_q <= bus.freq_word;
      end else if (bus.en && (bus.mode == MODE_SWEEP)) begin
        if (sweep_over) begin
          freq_cur_q <= freq_start_q;
          wrap_q     <= 1'b1;
        end else begin
          freq_cur_q <= sweep_next[PHASE_W-1:0];
        end
      end
      if (bus.phase_clr) begin
        acc_q <= '0;
      end else if (bus.en) begin
        acc_q <= acc_q + freq_cur_q;
      end
    end
  end

  // Stage 1: offset phase, truncate to lookup bits, derive cosine phase
  logic [PHASE_W-1:0] phase_sum;
  logic [ADDR_W-1:0]  p_d;
  logic [ADDR_W-1:0]  p1_q;
  logic [ADDR_W-1:0]  pc1_q;
  logic               v1_q;
  logic               w1_q;

  assign phase_sum = acc_q + bus.phase_off;
  assign p_d       = ADDR_W'(phase_sum >> (PHASE_W - ADDR_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q  <= '0;
      pc1_q <= '0;
      v1_q  <= 1'b0;
      w1_q  <= 1'b0;
    end else begin
      p1_q  <= p_d;
      pc1_q <= p_d + Quarter;
      v1_q  <= bus.en;
      w1_q  <= wrap_q;
    end
  end

  // Stage 2: quadrant fold into the ROM, registered lookups
  logic [IDX_W-1:0] sin_addr;
  logic [IDX_W-1:0] cos_addr;
  logic [OUT_W-1:0] sin_mag;
  logic [OUT_W-1:0] cos_mag;
  logic             neg_s2_q;
  logic             neg_c2_q;
  logic             v2_q;
  logic             w2_q;

  assign sin_addr = p1_q[IDX_W]  ? ~p1_q[IDX_W-1:0]  : p1_q[IDX_W-1:0];
  assign cos_addr = pc1_q[IDX_W] ? ~pc1_q[IDX_W-1:0] : pc1_q[IDX_W-1:0];

  quarter_sine_rom #(
    .IDX_W (IDX_W),
    .OUT_W (OUT_W)
  ) u_rom (
    .clk    (clk),
    .addr_a (sin_addr),
    .addr_b (cos_addr),
    .data_a (sin_mag),
    .data_b (cos_mag)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_s2_q <= 1'b0;
      neg_c2_q <= 1'b0;
      v2_q     <= 1'b0;
      w2_q     <= 1'b0;
    end else begin
      neg_s2_q <= p1_q[ADDR_W-1];
      neg_c2_q <= pc1_q[ADDR_W-1];
      v2_q     <= v1_q;
      w2_q     <= w1_q;
    end
  end

  // Stage 3: sign restore and output registers
  logic [OUT_W-1:0] sin_q;
  logic [OUT_W-1:0] cos_q;
  logic             valid_q;
  logic             wrap_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sin_q      <= '0;
      cos_q      <= '0;
      valid_q    <= 1'b0;
      wrap_out_q <= 1'b0;
    end else begin
      sin_q      <= neg_s2_q ? -sin_mag : sin_mag;
      cos_q      <= neg_c2_q ? -cos_mag : cos_mag;
      valid_q    <= v2_q;
      wrap_out_q <= w2_q;
    end
  end

  assign bus.sin_out    = sin_q;
  assign bus.cos_out    = cos_q;
  assign bus.out_valid  = valid_q;
  assign bus.sweep_wrap = wrap_out_q;

endmodule

// File: tb/tb_nco_sweep_gen.sv
// Scoreboard bench for nco_sweep_gen: reference model predicts each sample three cycles ahead.
module tb_nco_sweep_gen;
  import nco_sweep_gen_pkg::*;

  localparam int PW = 16;
  localparam int AW = 10;
  localparam int OW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nco_sweep_gen_if #(.PHASE_W(PW), .OUT_W(OW)) bus ();

  nco_sweep_gen #(.PHASE_W(PW), .ADDR_W(AW), .OUT_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit chk;
    bit valid;
    bit wrap;
    int cosv;
    int sinv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   sb_on = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   ref_rom[256];

  logic [PW-1:0] m_acc, m_fstart, m_fcur;
  bit            m_wrap;

  function automatic int lut(int p);
    int q, i, idx;
    q   = (p >> 8) & 3;
    i   = p & 255;
    idx = (q % 2 == 1) ? 255 - i : i;
    return (q >= 2) ? -ref_rom[idx] : ref_rom[idx];
  endfunction

  function automatic int s_out();
    return int'($signed(bus.sin_out));
  endfunction

  function automatic int c_out();
    return int'($signed(bus.cos_out));
  endfunction

  always @(posedge clk) begin
    #1;
    if (sb_on && sb.size() >= 3) begin
      mon_e = sb.pop_front();
      total++;
      if (bus.out_valid !== mon_e.valid || bus.sweep_wrap !== mon_e.wrap ||
          (mon_e.chk && (s_out() != mon_e.sinv || c_out() != mon_e.cosv))) begin
        bad++;
        $display("FAIL sb t=%0t got v=%0b w=%0b sin=%0d cos=%0d exp v=%0b w=%0b sin=%0d cos=%0d",
                 $time, bus.out_valid, bus.sweep_wrap, s_out(), c_out(),
                 mon_e.valid, mon_e.wrap, mon_e.sinv, mon_e.cosv);
      end
    end
  end

  // One clock: push prediction for the sample captured at this edge, then advance the model.
  task automatic step();
    exp_t          e;
    logic [PW-1:0] sum, f_old;
    logic [PW:0]   nxt;
    int            p;
    sum    = m_acc + bus.phase_off;
    p      = int'(sum >> (PW - AW));
    e.chk  = 1'b1;
    e.valid = bus.en;
    e.wrap = m_wrap;
    e.sinv = lut(p);
    e.cosv = lut((p + 256) % 1024);
    sb.push_back(e);
    f_old  = m_fcur;
    nxt    = {1'b0, m_fcur} + {1'b0, bus.sweep_step};
    m_wrap = 1'b0;
    if (bus.fw_load) begin
      m_fcur   = bus.freq_word;
      m_fstart = bus.freq_word;
    end else if (bus.en && bus.mode) begin
      if (nxt > {1'b0, bus.sweep_stop}) begin
        m_fcur = m_fstart;
        m_wrap = 1'b1;
      end else begin
        m_fcur = nxt[PW-1:0];
      end
    end
    if (bus.phase_clr) m_acc = '0;
    else if (bus.en) m_acc = m_acc + f_old;
    @(posedge clk);
    #2;
  endtask

  // Holds rst for one edge; the two in-flight slots after release are checked for valid/wrap only.
  task automatic apply_reset();
    exp_t ph;
    sb_on = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    ph = '{chk: 1'b0, valid: 1'b0, wrap: 1'b0, cosv: 0, sinv: 0};
    sb.push_back(ph);
    sb.push_back(ph);
    m_acc = '0; m_fstart = '0; m_fcur = '0; m_wrap = 1'b0;
    sb_on = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (bus.out_valid !== 1'b0 || bus.sweep_wrap !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags got v=%0b w=%0b exp 0 0", bus.out_valid, bus.sweep_wrap);
    end
    total++;
    if (bus.sin_out !== '0 || bus.cos_out !== '0) begin
      bad++;
      $display("FAIL reset_data got sin=%0d cos=%0d exp 0 0", s_out(), c_out());
    end
  endtask

  task automatic test_dc();
    int offs[3] = '{0, 16'h4000, 16'h8000};
    int es[3]   = '{2, 511, -2};
    int ec[3]   = '{511, -2, -511};
    bus.fw_load = 1'b1; bus.freq_word = '0; bus.en = 1'b1; bus.mode = MODE_FIXED;
    step();
    bus.fw_load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.phase_off = PW'(offs[k]);
      repeat (5) step();
      total++;
      if (bus.out_valid !== 1'b1 || s_out() != es[k] || c_out() != ec[k]) begin
        bad++;
        $display("FAIL dc_%0d got v=%0b sin=%0d cos=%0d exp v=1 sin=%0d cos=%0d",
                 k, bus.out_valid, s_out(), c_out(), es[k], ec[k]);
      end
    end
    bus.phase_off = '0;
  endtask

  task automatic test_fixed();
    int s[128];
    int mx, mn, per_bad;
    bus.fw_load = 1'b1; bus.freq_word = 16'h0400; bus.phase_clr = 1'b1; bus.en = 1'b0;
    step();
    bus.fw_load = 1'b0; bus.phase_clr = 1'b0; bus.en = 1'b1;
    repeat (16) step();
    bus.en = 1'b0;
    repeat (3) step();
    total++;
    if (bus.out_valid !== 1'b0 || s_out() != 511 || c_out() != -2) begin
      bad++;
      $display("FAIL acc16_hold got v=%0b sin=%0d cos=%0d exp v=0 sin=511 cos=-2",
               bus.out_valid, s_out(), c_out());
    end
    bus.en = 1'b1;
    repeat (3) step();
    mx = -1000; mn = 1000; per_bad = 0;
    for (int k = 0; k < 128; k++) begin
      step();
      s[k] = s_out();
      if (s[k] > mx) mx = s[k];
      if (s[k] < mn) mn = s[k];
    end
    for (int k = 0; k < 64; k++) begin
      if (s[k] != s[k+64] || s[k] != -s[(k+32)%64 + 64 - 64 + ((k+32)/64)*64]) per_bad++;
    end
    total++;
    if (per_bad != 0) begin
      bad++;
      $display("FAIL period64 got %0d differing samples exp 0", per_bad);
    end
    total++;
    if (mx != 511 || mn != -511) begin
      bad++;
      $display("FAIL sin_range got max=%0d min=%0d exp max=511 min=-511", mx, mn);
    end
  endtask

  task automatic test_sweep();
    int first, cnt, held;
    bus.fw_load = 1'b1; bus.freq_word = 16'h0100; bus.phase_clr = 1'b1; bus.en = 1'b0;
    bus.mode = MODE_SWEEP; bus.sweep_step = 16'h0100; bus.sweep_stop = 16'h0400;
    step();
    bus.fw_load = 1'b0; bus.phase_clr = 1'b0; bus.en = 1'b1;
    first = -1; cnt = 0;
    for (int j = 1; j <= 16; j++) begin
      step();
      if (bus.sweep_wrap === 1'b1) begin
        cnt++;
        if (first < 0) first = j;
      end
    end
    total++;
    if (first != 7 || cnt != 3) begin
      bad++;
      $display("FAIL wrap_timing got first=%0d count=%0d exp first=7 count=3", first, cnt);
    end
    bus.en = 1'b0;
    repeat (3) step();
    held = s_out();
    repeat (3) step();
    total++;
    if (s_out() != held || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL sweep_freeze got sin=%0d v=%0b exp sin=%0d v=0", s_out(), bus.out_valid, held);
    end
    bus.en = 1'b1;
    repeat (12) step();
  endtask

  task automatic test_load_clr();
    bus.fw_load = 1'b1; bus.freq_word = 16'h0400; bus.en = 1'b0; bus.mode = MODE_SWEEP;
    step();
    bus.freq_word = 16'h0200; bus.en = 1'b1;
    step();
    bus.fw_load = 1'b0;
    repeat (3) step();
    total++;
    if (bus.sweep_wrap !== 1'b0) begin
      bad++;
      $display("FAIL load_beats_wrap got wrap=%0b exp 0", bus.sweep_wrap);
    end
    repeat (4) step();
    bus.mode = MODE_FIXED; bus.phase_clr = 1'b1;
    step();
    bus.phase_clr = 1'b0; bus.en = 1'b0;
    repeat (3) step();
    total++;
    if (s_out() != 2 || c_out() != 511) begin
      bad++;
      $display("FAIL phase_clr got sin=%0d cos=%0d exp sin=2 cos=511", s_out(), c_out());
    end
  endtask

  task automatic test_mid_reset();
    bus.fw_load = 1'b1; bus.freq_word = 16'h0100; bus.mode = MODE_SWEEP; bus.en = 1'b1;
    step();
    bus.fw_load = 1'b0;
    repeat (6) step();
    apply_reset();
    total++;
    if (bus.out_valid !== 1'b0 || bus.sin_out !== '0 || bus.cos_out !== '0) begin
      bad++;
      $display("FAIL midrst_zero got v=%0b sin=%0d cos=%0d exp 0 0 0",
               bus.out_valid, s_out(), c_out());
    end
    bus.mode = MODE_FIXED;
    for (int j = 1; j <= 3; j++) begin
      step();
      total++;
      if (bus.out_valid !== (j == 3)) begin
        bad++;
        $display("FAIL midrst_valid_%0d got v=%0b exp %0b", j, bus.out_valid, j == 3);
      end
    end
    repeat (3) step();
    total++;
    if (s_out() != 2 || c_out() != 511) begin
      bad++;
      $display("FAIL midrst_restart got sin=%0d cos=%0d exp sin=2 cos=511", s_out(), c_out());
    end
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      ref_rom[k] = $rtoi(511.0 * $sin(3.141592653589793 / 2.0 * (real'(k) + 0.5) / 256.0) + 0.5);
    end
    rst = 1'b1;
    bus.en = 1'b0; bus.fw_load = 1'b0; bus.freq_word = '0; bus.phase_off = '0;
    bus.phase_clr = 1'b0; bus.mode = MODE_FIXED; bus.sweep_step = '0; bus.sweep_stop = '0;
    test_reset();
    test_dc();
    test_fixed();
    test_sweep();
    test_load_clr();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
